cmos_parity_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-bit XOR/XNOR cell.
- Reduces a WIDTH-bit word to odd parity (XOR) and even parity (XNOR) through a two-stage registered tree, with valid/ready handshaking on both sides.
- Adds a frame-accumulate mode: parity is folded across multi-beat frames, and the beat count is reported.
- Sits between datapath producers and the link or ECC logic that consumes parity.

---
 rtl/cmos_parity_pipe.sv | 148 ++++++++++++++
 tb/tb_cmos_parity_pipe.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmos_parity_pipe.sv
`timescale 1ns/1ps
// cmos_parity_pipe: two-stage registered XOR/XNOR reduction with frame accumulate.
// Define CMOS_PARITY_CHECK_EN to add the in_par / out_err parity check.
module cmos_parity_pipe #(
  parameter int WIDTH = 8,
  parameter int GROUP = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic             in_first,
  input  logic             in_last,
`ifdef CMOS_PARITY_CHECK_EN
  input  logic             in_par,
  output logic             out_err,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_xor,
  output logic             out_xnor,
  output logic [CNT_W-1:0] out_beats
);

  localparam int NP = (WIDTH + GROUP - 1) / GROUP;
  localparam int PW = NP * GROUP;

  logic             adv;
  logic [PW-1:0]    padded;
  logic [NP-1:0]    part;

  logic             s1_valid;
  logic [NP-1:0]    s1_part;
  logic             s1_mode;
  logic             s1_first;
  logic             s1_last;

  logic             acc;
  logic [CNT_W-1:0] cnt;
  logic             frame_open;

  logic             p;
  logic             start;
  logic             acc_n;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_n;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;
  assign out_xnor = ~out_xor;

  assign padded = PW'(in_data);

  always_comb begin
    part = '0;
    for (int g = 0; g < NP; g++) begin
      part[g] = ^padded[g*GROUP +: GROUP];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_part  <= '0;
      s1_mode  <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_part  <= part;
      s1_mode  <= in_mode;
      s1_first <= in_first;
      s1_last  <= in_last;
    end
  end

  // acc/cnt are zero whenever no frame is open, so an implicit start is a restart
  assign p       = ^s1_part;
  assign start   = s1_first | ~frame_open;
  assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);
  assign acc_n   = start ? p : (acc ^ p);
  assign cnt_n   = start ? CNT_W'(1) : cnt_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_xor    <= 1'b0;
      out_beats  <= '0;
      acc        <= 1'b0;
      cnt        <= '0;
      frame_open <= 1'b0;
    end else if (adv) begin
      if (!s1_valid) begin
        out_valid <= 1'b0;
      end else if (!s1_mode) begin
        out_xor   <= p;
        out_beats <= CNT_W'(1);
        out_valid <= 1'b1;
      end else if (s1_last) begin
        out_xor    <= acc_n;
        out_beats  <= cnt_n;
        out_valid  <= 1'b1;
        acc        <= 1'b0;
        cnt        <= '0;
        frame_open <= 1'b0;
      end else begin
        acc        <= acc_n;
        cnt        <= cnt_n;
        frame_open <= 1'b1;
        out_valid  <= 1'b0;
      end
    end
  end

`ifdef CMOS_PARITY_CHECK_EN
  logic s1_par;
  logic err_acc;
  logic beat_err;
  logic err_n;

  assign beat_err = s1_par ^ p;
  assign err_n    = start ? beat_err : (err_acc | beat_err);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_par  <= 1'b0;
      err_acc <= 1'b0;
      out_err <= 1'b0;
    end else if (adv) begin
      s1_par <= in_par;
      if (s1_valid) begin
        if (!s1_mode) begin
          out_err <= beat_err;
        end else if (s1_last) begin
          out_err <= err_n;
          err_acc <= 1'b0;
        end else begin
          err_acc <= err_n;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_cmos_parity_pipe.sv
`timescale 1ns/1ps
// tb_cmos_parity_pipe: directed vectors, expected results queued at issue
// and popped by an independent output monitor.
module tb_cmos_parity_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       in_mode;
  logic       in_first;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic       out_xor;
  logic       out_xnor;
  logic [7:0] out_beats;
`ifdef CMOS_PARITY_CHECK_EN
  logic       in_par;
  logic       out_err;
`endif

  cmos_parity_pipe #(.WIDTH(8), .GROUP(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_first  (in_first),
    .in_last   (in_last),
`ifdef CMOS_PARITY_CHECK_EN
    .in_par    (in_par),
    .out_err   (out_err),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_xor   (out_xor),
    .out_xnor  (out_xnor),
    .out_beats (out_beats)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       x;
    logic [7:0] b;
    logic       e;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // caller is at negedge+1; returns at negedge+1 after the accepting edge
  task automatic send(input logic [7:0] d, input logic m, input logic f,
                      input logic l, input logic b, input logic ex,
                      input int eb, input logic ee);
    exp_t e;
    int   g;
    e.x = ex;
    e.b = 8'(eb);
    e.e = ee;
    if (!m || l) q.push_back(e);
    in_data  = d;
    in_mode  = m;
    in_first = f;
    in_last  = l;
`ifdef CMOS_PARITY_CHECK_EN
    in_par   = (^d) ^ b;
`endif
    in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 100) begin
      @(negedge clk); #1;
      g++;
    end
    if (g >= 100) chk("in_ready_timeout", 0, 1);
    @(negedge clk); #1;
    in_valid = 1'b0;
  endtask

  logic       st;
  logic       px;
  logic [7:0] pb;
  exp_t       me;

  initial begin
    st = 1'b0;
    px = 1'b0;
    pb = '0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        st = 1'b0;
      end else if (out_valid) begin
        if (st) begin
          chk("stall_xor", out_xor, px);
          chk("stall_beats", out_beats, pb);
        end
        if (out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_out", 1, 0);
          end else begin
            me = q.pop_front();
            chk("out_xor", out_xor, me.x);
            chk("out_xnor", out_xnor, !me.x);
            chk("out_beats", out_beats, me.b);
`ifdef CMOS_PARITY_CHECK_EN
            chk("out_err", out_err, me.e);
`endif
          end
          st = 1'b0;
        end else begin
          st = 1'b1;
          px = out_xor;
          pb = out_beats;
        end
      end else begin
        st = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1);
  end

  initial begin
    int g;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 1'b0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
`ifdef CMOS_PARITY_CHECK_EN
    in_par    = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_xor", out_xor, 0);
    chk("rst_xnor", out_xnor, 1);
    chk("rst_beats", out_beats, 0);
    chk("rst_in_ready", in_ready, 1);
`ifdef CMOS_PARITY_CHECK_EN
    chk("rst_err", out_err, 0);
`endif

    send(8'hA5, 0, 0, 0, 0, 0, 1, 0);
    send(8'h07, 0, 0, 0, 0, 1, 1, 0);

    send(8'h01, 1, 1, 0, 0, 0, 0, 0);
    send(8'h03, 1, 0, 0, 0, 0, 0, 0);
    send(8'h07, 1, 0, 1, 0, 0, 3, 0);

    out_ready = 1'b0;
    fork
      begin
        send(8'h01, 0, 0, 0, 0, 1, 1, 0);
        send(8'h03, 0, 0, 0, 0, 0, 1, 0);
        send(8'h7F, 0, 0, 0, 0, 1, 1, 0);
      end
      begin
        repeat (3) @(negedge clk);
        #1;
        chk("in_ready_stall", in_ready, 0);
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
      end
    join

    send(8'h01, 1, 1, 0, 0, 0, 0, 0);
    send(8'h03, 0, 0, 0, 0, 0, 1, 0);
    send(8'h01, 1, 0, 1, 0, 0, 2, 0);

    send(8'h01, 1, 1, 0, 0, 0, 0, 0);
    send(8'h01, 1, 1, 0, 0, 0, 0, 0);
    send(8'h03, 1, 0, 1, 0, 1, 2, 0);

    send(8'h07, 1, 0, 0, 0, 0, 0, 0);
    send(8'h01, 1, 0, 1, 0, 0, 2, 0);

    send(8'h01, 1, 1, 1, 0, 1, 1, 0);

    for (int i = 0; i < 256; i++) begin
      send(8'h01, 1, i == 0, i == 255, 0, 0, 255, 0);
    end

    send(8'h01, 1, 1, 0, 0, 0, 0, 0);
    send(8'h03, 1, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_beats", out_beats, 0);
    rst = 1'b0;
    @(negedge clk); #1;
    send(8'h01, 1, 0, 1, 0, 1, 1, 0);
    send(8'h01, 1, 1, 1, 0, 1, 1, 0);

`ifdef CMOS_PARITY_CHECK_EN
    send(8'h01, 1, 1, 0, 0, 0, 0, 0);
    send(8'h03, 1, 0, 0, 1, 0, 0, 0);
    send(8'h07, 1, 0, 1, 0, 0, 3, 1);
    send(8'h01, 1, 1, 0, 0, 0, 0, 0);
    send(8'h01, 1, 0, 1, 0, 0, 2, 0);
    send(8'h05, 0, 0, 0, 1, 0, 1, 1);
    send(8'h05, 0, 0, 0, 0, 0, 1, 0);
`endif

    g = 0;
    while ((q.size() != 0 || out_valid) && g < 500) begin
      @(negedge clk); #1;
      g++;
    end
    chk("drain_left", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
